// File: rtl/keypad_pkg.sv
// keypad_pkg: shared event FSM encoding, row drive table and queue depth (KEYPAD_FIFO_EN selects depth 4)
package keypad_pkg;
  typedef enum logic {IDLE, EMIT} ev_state_t;
  localparam logic [15:0] ROW_ONEHOT = 16'b1000_0100_0010_0001;
`ifdef KEYPAD_FIFO_EN
  localparam int FIFO_DEPTH = 4;
`else
  localparam int FIFO_DEPTH = 1;
`endif
  function automatic logic [3:0] lowest_index(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: key event queue, 4-entry FIFO with KEYPAD_FIFO_EN, single holding register otherwise
module keypad_event_fifo
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       valid,
  output logic       overflow
);
  logic pop_ok, full, acc;
  assign pop_ok = pop && valid;
  assign acc = push && (!full || pop_ok);
  // a push is dropped only when the queue is full and nothing leaves this cycle
  always_ff @(posedge clk) overflow <= reset ? 1'b0 : push && full && !pop_ok;
`ifdef KEYPAD_FIFO_EN
  logic [3:0] mem [FIFO_DEPTH];
  logic [1:0] rd, wr;
  logic [2:0] cnt;
  assign full = cnt == 3'(FIFO_DEPTH);
  assign valid = cnt != 3'd0;
  assign dout = mem[rd];
  // circular buffer; head entry stays put until popped
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
      rd <= 2'd0;
      wr <= 2'd0;
      cnt <= 3'd0;
    end else begin
      if (acc) mem[wr] <= din;
      wr <= wr + 2'(acc);
      rd <= rd + 2'(pop_ok);
      cnt <= cnt + 3'(acc) - 3'(pop_ok);
    end
`else
  logic [3:0] hold;
  logic full_r;
  assign full = full_r;
  assign valid = full_r;
  assign dout = hold;
  // single holding register; refilled in the same cycle it is popped
  always_ff @(posedge clk)
    if (reset) begin
      hold <= 4'd0;
      full_r <= 1'b0;
    end else if (acc) begin
      hold <= din;
      full_r <= 1'b1;
    end else if (pop_ok) full_r <= 1'b0;
`endif
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounce and key press event queue (define KEYPAD_FIFO_EN for a 4-entry queue)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  rows_n,
  input  logic [3:0]  cols_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic [15:0] pressed,
  output logic        overflow
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [3:0] c1, c2, code;
  logic [DW-1:0] div;
  logic [1:0] row;
  logic [11:0] snap;
  logic [15:0] prev, scan, rise, pending, pending_nxt, low;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last, done, upd, push;
  ev_state_t state, state_nxt;
  assign rows_n = ~ROW_ONEHOT[{row, 2'b00} +: 4];
  assign last = div == DW'(SCAN_DIV - 1);
  assign done = last && row == 2'd3;
  assign scan = {~c2, snap};
  assign cnt_nxt = scan != prev ? CW'(1) : cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + 1'b1;
  assign upd = done && cnt_nxt == CW'(DEBOUNCE_SCANS);
  assign rise = upd ? scan & ~pressed : 16'd0;
  assign low = pending & (~pending + 16'd1);
  assign code = lowest_index(pending);
  // two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk)
    if (reset) {c1, c2} <= 8'hFF;
    else {c1, c2} <= {cols_n, c1};
  // row walk; columns are captured on the last count of each row (row 3 goes straight into the scan)
  always_ff @(posedge clk)
    if (reset) begin
      div <= '0;
      row <= 2'd0;
      snap <= 12'd0;
    end else begin
      div <= last ? '0 : div + 1'b1;
      if (last) begin
        row <= row + 2'd1;
        snap <= (snap & ~(12'hF << {row, 2'b00})) | (12'(~c2) << {row, 2'b00});
      end
    end
  // debounce: accept a key map once DEBOUNCE_SCANS consecutive scans agree
  always_ff @(posedge clk)
    if (reset) begin
      prev <= 16'd0;
      cnt <= '0;
      pressed <= 16'd0;
    end else if (done) begin
      prev <= scan;
      cnt <= cnt_nxt;
      if (upd) pressed <= scan;
    end
  // event FSM next state: drain pending presses lowest index first, one per cycle
  always_comb begin
    push = state == EMIT && |pending;
    pending_nxt = (pending & ~(push ? low : 16'd0)) | rise;
    state_nxt = state == IDLE ? (|pending ? EMIT : IDLE) : (|pending_nxt ? EMIT : IDLE);
  end
  // event FSM state and pending mask
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pending <= 16'd0;
    end else begin
      state <= state_nxt;
      pending <= pending_nxt;
    end
  keypad_event_fifo u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(key_ack),
    .din(code),
    .dout(key_code),
    .valid(key_valid),
    .overflow(overflow)
  );
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 5000: clock cycles each row stays driven.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a key map.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rows_n, output, 4: row drive, active-low, at most one bit low.
REQ-006 SHALL have port cols_n, input, 4: column sense, active-low, asynchronous to clk.
REQ-007 SHALL have port key_code, output, 4: code of the key at the head of the queue, equal to row*4+col.
REQ-008 SHALL have port key_valid, output, 1: key_code holds an unconsumed event.
REQ-009 SHALL have port key_ack, input, 1: consumer pops the head event.
REQ-010 SHALL have port pressed, output, 16: debounced key map, bit row*4+col.
REQ-011 SHALL have port overflow, output, 1: one-cycle pulse when an event is dropped.

Function
REQ-012 SHALL pass cols_n through a 2-flop synchronizer before any use.
REQ-013 SHALL use a divider counting 0..SCAN_DIV-1 and a 2-bit row index that advances 0->1->2->3->0 on divider wrap; rows_n is the inverse of one-hot(row).
REQ-014 SHALL sample the synchronized columns on the divider's last count (SCAN_DIV-1) of each row into snapshot bits row*4+3..row*4.
REQ-015 SHALL complete a scan when row 3 is sampled; the completed 16-bit snapshot is compared with the previous scan's snapshot.
REQ-016 SHALL increment a match counter (saturating at DEBOUNCE_SCANS) on equality, reload it to 1 on inequality, and copy the snapshot to pressed on the scan where the counter reaches DEBOUNCE_SCANS.
REQ-017 SHALL OR the newly pressed bits (new pressed AND NOT old pressed) into a 16-bit pending mask when pressed updates; releases generate no event.
REQ-018 SHALL run an event FSM with states IDLE and EMIT: IDLE->EMIT when pending!=0; in EMIT, each cycle push the lowest-index pending bit as key_code and clear it; EMIT->IDLE when pending becomes 0.
REQ-019 SHALL raise key_valid the cycle after the first push (1-cycle latency from push) and hold key_code/key_valid stable until key_ack.
REQ-020 SHALL pop on key_ack while key_valid=1; key_ack while key_valid=0 is ignored.
REQ-021 SHALL drop the event and pulse overflow when a push finds the queue full; a simultaneous pop and push on a full queue is accepted without overflow.
REQ-022 SHALL never drive more than one row low, including on reset release.

Reset
REQ-023 SHALL on reset set rows_n=4'b1110, row=0, divider=0, snapshots=0, match counter=0, pressed=0, pending=0, queue empty, key_valid=0, key_code=0, overflow=0, FSM=IDLE.
REQ-024 SHALL abort any scan or emission in progress on reset; no event generated before reset survives it.

Configuration
REQ-025 SHALL, with KEYPAD_FIFO_EN defined, queue events in a 4-entry FIFO (full at 4).
REQ-026 SHALL, without KEYPAD_FIFO_EN, queue events in a single holding register (full at 1); the interface is identical.

Structure
REQ-027 SHALL place the FSM state encoding, the row one-hot table and the FIFO depth constant in shared package keypad_pkg.
REQ-028 SHALL implement the queue as sub-module keypad_event_fifo, with depth selected by KEYPAD_FIFO_EN.

Verification
REQ-029 SHALL check: reset, SCAN_DIV=4 -> rows_n walks 1110,1101,1011,0111, 4 cycles per row, repeating.
REQ-030 SHALL check: key 6 (row1,col2) held steady, DEBOUNCE_SCANS=4 -> pressed[6]=1 after the 4th matching scan; key_code=6 with key_valid=1; key_ack -> key_valid=0.
REQ-031 SHALL check: key 6 bouncing on alternate scans -> pressed stays 0 and no event is generated.
REQ-032 SHALL check: keys 3 and 9 pressed together and stable -> events pop in order 3 then 9.
REQ-033 SHALL check: with KEYPAD_FIFO_EN and no ack, 5 distinct presses -> 4 are queued and overflow pulses once; without KEYPAD_FIFO_EN, 2 presses -> 1 is queued and overflow pulses once.
REQ-034 SHALL check: reset asserted mid-EMIT with 2 pending -> key_valid=0, pending=0 and rows_n=1110 the next cycle.
